// File: rtl/snake_trail_fb_if.sv
// rtl/snake_trail_fb_if.sv - move handshake and framebuffer RAM port bundle
// The controller takes the master side; the key decoder / RAM side takes slave.
interface snake_trail_fb_if #(
   parameter int A_W = 10
);
   logic           move_valid;
   logic [1:0]     move_dir;
   logic           move_ready;
   logic [A_W-1:0] ram_rd_addr;
   logic [7:0]     ram_rd_data;
   logic [A_W-1:0] ram_wr_addr;
   logic [7:0]     ram_wr_data;
   logic           ram_wr_en;

   modport master (
      input  move_valid, move_dir, ram_rd_data,
      output move_ready, ram_rd_addr, ram_wr_addr, ram_wr_data, ram_wr_en
   );

   modport slave (
      output move_valid, move_dir, ram_rd_data,
      input  move_ready, ram_rd_addr, ram_wr_addr, ram_wr_data, ram_wr_en
   );
endinterface

// File: rtl/snake_trail_fb.sv
// rtl/snake_trail_fb.sv - snake head + trail history with RMW on a paged mono framebuffer
// Define SNAKE_WRAP_EN to wrap the head at screen edges; otherwise off-screen moves are ignored.
module snake_trail_fb #(
   parameter int COLS      = 128,
   parameter int PAGES     = 8,
   parameter int TRAIL_LEN = 16,
   parameter int RD_LAT    = 2,
   parameter int X_W       = $clog2(COLS),
   parameter int Y_W       = $clog2(PAGES*8),
   parameter int A_W       = $clog2(COLS*PAGES),
   parameter int C_W       = $clog2(TRAIL_LEN) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   snake_trail_fb_if.master     bus,
   input  logic                 pen_toggle,
   input  logic                 clear_req,
   output logic                 pen_on,
   output logic                 busy,
   output logic [X_W-1:0]       head_x,
   output logic [Y_W-1:0]       head_y,
   output logic [C_W-1:0]       trail_cnt
);
   localparam int P_W = $clog2(TRAIL_LEN);
   localparam int W_W = $clog2(RD_LAT + 1);
   localparam logic [X_W-1:0] X_MAX     = X_W'(COLS - 1);
   localparam logic [Y_W-1:0] Y_MAX     = Y_W'(PAGES*8 - 1);
   localparam logic [A_W-1:0] CLR_LAST  = A_W'(COLS*PAGES - 1);
   localparam logic [W_W-1:0] WAIT_LAST = W_W'(RD_LAT - 2);

   localparam logic [2:0] ST_CLEAR  = 3'd0;
   localparam logic [2:0] ST_IDLE   = 3'd1;
   localparam logic [2:0] ST_E_RD   = 3'd2;
   localparam logic [2:0] ST_E_WAIT = 3'd3;
   localparam logic [2:0] ST_E_WR   = 3'd4;
   localparam logic [2:0] ST_S_RD   = 3'd5;
   localparam logic [2:0] ST_S_WAIT = 3'd6;
   localparam logic [2:0] ST_S_WR   = 3'd7;

   logic [2:0]     state;
   logic           rst_q;
   logic [A_W-1:0] clr_cnt;
   logic [W_W-1:0] wait_cnt;
   logic [P_W-1:0] wr_ptr;
   logic [X_W-1:0] hist_x [TRAIL_LEN];
   logic [Y_W-1:0] hist_y [TRAIL_LEN];
   logic [X_W-1:0] er_x;
   logic [Y_W-1:0] er_y;

   logic [X_W-1:0] nx;
   logic [Y_W-1:0] ny;
   logic           off_edge;
   logic           dup;
   logic           full;
   logic           erase_ph;
   logic [A_W-1:0] op_addr;
   logic [7:0]     bit_mask;

   function automatic logic [A_W-1:0] pix_addr(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
      return A_W'(y >> 3) * A_W'(COLS) + A_W'(x);
   endfunction

   // Bounds are compared explicitly because COLS need not be a power of two.
   always_comb begin
      nx       = head_x;
      ny       = head_y;
      off_edge = 1'b0;
      case (bus.move_dir)
         2'd0: if (head_y == '0) begin
`ifdef SNAKE_WRAP_EN
            ny = Y_MAX;
`else
            off_edge = 1'b1;
`endif
         end else ny = head_y - Y_W'(1);
         2'd1: if (head_y == Y_MAX) begin
`ifdef SNAKE_WRAP_EN
            ny = '0;
`else
            off_edge = 1'b1;
`endif
         end else ny = head_y + Y_W'(1);
         2'd2: if (head_x == '0) begin
`ifdef SNAKE_WRAP_EN
            nx = X_MAX;
`else
            off_edge = 1'b1;
`endif
         end else nx = head_x - X_W'(1);
         default: if (head_x == X_MAX) begin
`ifdef SNAKE_WRAP_EN
            nx = '0;
`else
            off_edge = 1'b1;
`endif
         end else nx = head_x + X_W'(1);
      endcase
   end

   // When full, wr_ptr names the oldest entry; it survives if anything else still covers it.
   always_comb begin
      dup = (nx == hist_x[wr_ptr]) && (ny == hist_y[wr_ptr]);
      for (int i = 0; i < TRAIL_LEN; i++) begin
         if (P_W'(i) != wr_ptr && hist_x[i] == hist_x[wr_ptr] && hist_y[i] == hist_y[wr_ptr])
            dup = 1'b1;
      end
   end

   assign full     = (trail_cnt == C_W'(TRAIL_LEN));
   assign erase_ph = (state == ST_E_RD) || (state == ST_E_WAIT) || (state == ST_E_WR);
   assign op_addr  = erase_ph ? pix_addr(er_x, er_y) : pix_addr(head_x, head_y);
   assign bit_mask = 8'd1 << (erase_ph ? er_y[2:0] : head_y[2:0]);

   assign busy           = (state != ST_IDLE);
   assign bus.move_ready = (state == ST_IDLE) && !clear_req && !pen_toggle;
   assign bus.ram_rd_addr = (state == ST_E_RD || state == ST_S_RD) ? op_addr : '0;
   assign bus.ram_wr_en   = (state == ST_CLEAR && !rst_q) || state == ST_E_WR || state == ST_S_WR;
   assign bus.ram_wr_addr = (state == ST_CLEAR) ? clr_cnt :
                            (state == ST_E_WR || state == ST_S_WR) ? op_addr : '0;
   assign bus.ram_wr_data = (state == ST_E_WR) ? (bus.ram_rd_data & ~bit_mask) :
                            (state == ST_S_WR) ? (bus.ram_rd_data | bit_mask) : 8'h00;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_CLEAR;
         rst_q     <= 1'b1;
         clr_cnt   <= '0;
         wait_cnt  <= '0;
         wr_ptr    <= '0;
         trail_cnt <= '0;
         pen_on    <= 1'b0;
         head_x    <= '0;
         head_y    <= '0;
         er_x      <= '0;
         er_y      <= '0;
      end else begin
         case (state)
            ST_CLEAR: begin
               // rst_q holds off the sweep for the cycle reset is released in.
               if (rst_q) rst_q <= 1'b0;
               else if (clr_cnt == CLR_LAST) begin
                  state     <= ST_IDLE;
                  clr_cnt   <= '0;
                  trail_cnt <= '0;
                  wr_ptr    <= '0;
               end else clr_cnt <= clr_cnt + A_W'(1);
            end
            ST_IDLE: begin
               if (clear_req) begin
                  state   <= ST_CLEAR;
                  clr_cnt <= '0;
               end else if (pen_toggle) begin
                  pen_on <= ~pen_on;
               end else if (bus.move_valid && !off_edge) begin
                  head_x <= nx;
                  head_y <= ny;
                  if (pen_on) begin
                     hist_x[wr_ptr] <= nx;
                     hist_y[wr_ptr] <= ny;
                     wr_ptr         <= wr_ptr + P_W'(1);
                     if (full) begin
                        er_x  <= hist_x[wr_ptr];
                        er_y  <= hist_y[wr_ptr];
                        state <= dup ? ST_S_RD : ST_E_RD;
                     end else begin
                        trail_cnt <= trail_cnt + C_W'(1);
                        state     <= ST_S_RD;
                     end
                  end
               end
            end
            ST_E_RD: begin
               wait_cnt <= '0;
               state    <= (RD_LAT == 1) ? ST_E_WR : ST_E_WAIT;
            end
            ST_E_WAIT: begin
               if (wait_cnt == WAIT_LAST) state <= ST_E_WR;
               else wait_cnt <= wait_cnt + W_W'(1);
            end
            ST_E_WR: state <= ST_S_RD;
            ST_S_RD: begin
               wait_cnt <= '0;
               state    <= (RD_LAT == 1) ? ST_S_WR : ST_S_WAIT;
            end
            ST_S_WAIT: begin
               if (wait_cnt == WAIT_LAST) state <= ST_S_WR;
               else wait_cnt <= wait_cnt + W_W'(1);
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_snake_trail_fb.sv
// tb/tb_snake_trail_fb.sv - scoreboard bench for snake_trail_fb (honours SNAKE_WRAP_EN)
module tb_snake_trail_fb;
   localparam int COLS = 128, PAGES = 8, TRAIL_LEN = 16, RD_LAT = 2;
   localparam int A_W = 10, X_W = 7, Y_W = 6, C_W = 5;
   localparam int NPIX = COLS * PAGES;

   typedef struct packed { logic [A_W-1:0] a; logic [7:0] d; } wr_t;
   typedef struct { int x; int y; } pos_t;

   logic clk, rst, pen_toggle, clear_req;
   logic pen_on, busy;
   logic [X_W-1:0] head_x;
   logic [Y_W-1:0] head_y;
   logic [C_W-1:0] trail_cnt;

   snake_trail_fb_if #(.A_W(A_W)) bus ();

   snake_trail_fb #(.COLS(COLS), .PAGES(PAGES), .TRAIL_LEN(TRAIL_LEN), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst), .bus(bus), .pen_toggle(pen_toggle), .clear_req(clear_req),
      .pen_on(pen_on), .busy(busy), .head_x(head_x), .head_y(head_y), .trail_cnt(trail_cnt)
   );

   int n_vec = 0, n_miscmp = 0;
   logic mon_en = 1'b0;

   logic [7:0] mem [NPIX];
   logic [7:0] rd_pipe [RD_LAT];
   logic [7:0] exp_fb [NPIX];
   wr_t  wq [$];
   pos_t hq [$];
   int   mx = 0, my = 0;
   bit   mpen = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < NPIX; i++) mem[i] = 8'hFF;
   end

   always @(posedge clk) begin
      rd_pipe[0] <= mem[bus.ram_rd_addr];
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      if (bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
   end
   assign bus.ram_rd_data = rd_pipe[RD_LAT-1];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miscmp++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en && bus.ram_wr_en) begin
         wr_t e;
         chk("wr_pending", 32'(wq.size() != 0), 1);
         if (wq.size() != 0) begin
            e = wq.pop_front();
            chk("wr_addr", 32'(bus.ram_wr_addr), 32'(e.a));
            chk("wr_data", 32'(bus.ram_wr_data), 32'(e.d));
         end
      end
   end

   task automatic push_wr(input pos_t p, input bit set);
      int a;
      logic [7:0] m;
      a = (p.y / 8) * COLS + p.x;
      m = 8'd1 << (p.y % 8);
      exp_fb[a] = set ? (exp_fb[a] | m) : (exp_fb[a] & ~m);
      wq.push_back({A_W'(a), exp_fb[a]});
   endtask

   task automatic push_clear();
      for (int a = 0; a < NPIX; a++) begin
         exp_fb[a] = 8'h00;
         wq.push_back({A_W'(a), 8'h00});
      end
      hq.delete();
   endtask

   task automatic count_busy(input int limit, output int n);
      n = 0;
      forever begin
         @(negedge clk);
         if (!busy) break;
         n++;
         if (n > limit) break;
      end
   endtask

   task automatic model_move(input logic [1:0] d, output int eb);
      int nx, ny;
      bit off, dp;
      pos_t p, np;
      nx = mx; ny = my; off = 0; eb = 0;
      case (d)
         2'd0: if (my == 0) begin
`ifdef SNAKE_WRAP_EN
            ny = PAGES*8 - 1;
`else
            off = 1;
`endif
         end else ny = my - 1;
         2'd1: if (my == PAGES*8 - 1) begin
`ifdef SNAKE_WRAP_EN
            ny = 0;
`else
            off = 1;
`endif
         end else ny = my + 1;
         2'd2: if (mx == 0) begin
`ifdef SNAKE_WRAP_EN
            nx = COLS - 1;
`else
            off = 1;
`endif
         end else nx = mx - 1;
         default: if (mx == COLS - 1) begin
`ifdef SNAKE_WRAP_EN
            nx = 0;
`else
            off = 1;
`endif
         end else nx = mx + 1;
      endcase
      if (!off) begin
         mx = nx; my = ny;
         if (mpen) begin
            np.x = nx; np.y = ny;
            hq.push_back(np);
            eb = RD_LAT + 1;
            if (hq.size() > TRAIL_LEN) begin
               p = hq.pop_front();
               dp = 0;
               foreach (hq[i]) if (hq[i].x == p.x && hq[i].y == p.y) dp = 1;
               if (!dp) begin
                  push_wr(p, 0);
                  eb += RD_LAT + 1;
               end
            end
            push_wr(np, 1);
         end
      end
   endtask

   task automatic do_move(input logic [1:0] d);
      int n, eb;
      @(negedge clk);
      model_move(d, eb);
      bus.move_valid = 1'b1;
      bus.move_dir   = d;
      #1 chk("move_ready", 32'(bus.move_ready), 1);
      @(posedge clk);
      #1 bus.move_valid = 1'b0;
      count_busy(20, n);
      chk("busy_cyc", n, eb);
      chk("head_x", 32'(head_x), mx);
      chk("head_y", 32'(head_y), my);
      chk("trail_cnt", 32'(trail_cnt), hq.size());
   endtask

   task automatic do_toggle();
      @(negedge clk);
      pen_toggle = 1'b1;
      #1 chk("ready_tog", 32'(bus.move_ready), 0);
      @(posedge clk);
      #1 pen_toggle = 1'b0;
      mpen = !mpen;
      @(negedge clk);
      chk("pen_on", 32'(pen_on), 32'(mpen));
   endtask

   initial begin
      int n;
      rst = 1'b1; pen_toggle = 1'b0; clear_req = 1'b0;
      bus.move_valid = 1'b0; bus.move_dir = 2'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_wr_en", 32'(bus.ram_wr_en), 0);
      chk("rst_wr_addr", 32'(bus.ram_wr_addr), 0);
      chk("rst_rd_addr", 32'(bus.ram_rd_addr), 0);
      chk("rst_ready", 32'(bus.move_ready), 0);
      chk("rst_busy", 32'(busy), 1);
      chk("rst_trail", 32'(trail_cnt), 0);
      chk("rst_pen", 32'(pen_on), 0);
      chk("rst_head", 32'({head_x, head_y}), 0);
      mon_en = 1'b1;
      push_clear();
      rst = 1'b0;
      count_busy(1100, n);
      chk("clear_busy", n, NPIX);
      chk("clear_ready", 32'(bus.move_ready), 1);
      chk("clear_pen", 32'(pen_on), 0);
      chk("mem_0", 32'(mem[0]), 0);
      chk("mem_last", 32'(mem[NPIX-1]), 0);

      do_toggle();
      do_move(2'd3);
      chk("px_1_set", 32'(mem[1]), 8'h01);

      for (int i = 0; i < 16; i++) do_move(2'd3);
      chk("px_1_erased", 32'(mem[1]), 8'h00);
      chk("px_17_set", 32'(mem[17]), 8'h01);

      do_toggle();
      for (int i = 0; i < 12; i++) do_move(2'd2);
      do_toggle();
      for (int i = 0; i < 20; i++) do_move((i % 2 == 0) ? 2'd1 : 2'd0);
      chk("px_5_dup", 32'(mem[5]), 8'h03);

      do_toggle();
      for (int i = 0; i < 5; i++) do_move(2'd2);
      do_toggle();
      do_move(2'd2);
      do_move(2'd0);

      @(negedge clk);
      clear_req      = 1'b1;
      bus.move_valid = 1'b1;
      bus.move_dir   = 2'd3;
      #1 chk("ready_clr", 32'(bus.move_ready), 0);
      push_clear();
      @(posedge clk);
      #1 begin clear_req = 1'b0; bus.move_valid = 1'b0; end
      count_busy(1100, n);
      chk("clr2_busy", n, NPIX);
      chk("clr2_trail", 32'(trail_cnt), 0);
      chk("clr2_head_x", 32'(head_x), mx);
      chk("clr2_head_y", 32'(head_y), my);
      chk("clr2_pen", 32'(pen_on), 32'(mpen));
      do_move(2'd1);

      repeat (4) @(negedge clk);
      chk("wq_drained", wq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end
endmodule

// File: doc/snake_trail_fb.md
Name: snake_trail_fb

Overview:
- Parametrised successor to the single-snake LCD pixel controller.
- Keeps a moving head and a fixed-length trail history for a page-organised monochrome framebuffer: each byte is one column of 8 vertical pixels, and the address is page*COLS + x.
- Each accepted move does a read-modify-write: erase the oldest trail pixel, then set the new head pixel.
- Sits between the key decoder and the display framebuffer RAM. Adds a valid/ready handshake, a full-screen clear sweep, configurable read latency and duplicate-safe erase.

Parameters:
- COLS, 128, framebuffer width in pixels/columns.
- PAGES, 8, number of 8-pixel pages (height = PAGES*8).
- TRAIL_LEN, 16, maximum lit trail positions; must be a power of 2, at least 2.
- RD_LAT, 2, RAM read latency in cycles, at least 1.
- Derived widths: X_W = clog2(COLS), Y_W = clog2(PAGES*8), A_W = clog2(COLS*PAGES).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- move_valid  in  1  move request.
- move_dir  in  2  0=up (y-1), 1=down (y+1), 2=left (x-1), 3=right (x+1).
- move_ready  out  1  high only in IDLE; a move is accepted when move_valid & move_ready.
- pen_toggle  in  1  one-cycle pulse that toggles pen_on; acted on only in IDLE.
- clear_req  in  1  one-cycle pulse that starts a clear sweep; acted on only in IDLE.
- pen_on  out  1  drawing enabled.
- busy  out  1  FSM not in IDLE.
- head_x  out  X_W  current head x.
- head_y  out  Y_W  current head y.
- trail_cnt  out  clog2(TRAIL_LEN)+1  number of valid history entries.
- ram_rd_addr  out  A_W  framebuffer read address.
- ram_rd_data  in  8  read data, valid RD_LAT cycles after the address.
- ram_wr_addr  out  A_W  write address.
- ram_wr_data  out  8  write data.
- ram_wr_en  out  1  write strobe.

Behaviour:
- Reset, sampled on posedge:
  - FSM goes to CLEAR; head=(0,0); trail_cnt=0; pen_on=0.
  - ram_wr_en=0; all address and data outputs 0; move_ready=0.
  - Reset asserted mid-operation aborts everything and restarts the clear sweep.
- FSM states: CLEAR, IDLE, E_RD, E_WAIT, E_WR, S_RD, S_WAIT, S_WR.
- CLEAR:
  - Writes 0x00 to addresses 0..COLS*PAGES-1, one per cycle, with ram_wr_en=1.
  - Then goes to IDLE and resets trail_cnt to 0.
  - clear_req in IDLE enters CLEAR; head and pen_on are kept.
- IDLE priority when events coincide: clear_req, then pen_toggle, then move.
  - Lower-priority events in the same cycle are dropped.
  - move_ready=0 in any cycle where clear_req or pen_toggle is high.
- Move with pen_on=0:
  - Accepted and updates the head.
  - No history push, no RAM access, stays in IDLE.
- Move with pen_on=1:
  - The head updates in the accept cycle.
  - New head is pushed into a circular history of TRAIL_LEN entries.
  - If trail_cnt was TRAIL_LEN before the push, the oldest entry is popped and the FSM goes to E_RD. Otherwise trail_cnt increments and the FSM goes to S_RD.
- Duplicate-safe erase:
  - The erase is skipped (go straight to S_RD) if the popped position equals any entry remaining in the history, including the new head.
- RMW sequence, for both erase and set:
  - *_RD drives the address for 1 cycle.
  - *_WAIT lasts RD_LAT-1 cycles (skipped when RD_LAT=1).
  - *_WR captures ram_rd_data and writes it back with ram_wr_en=1 for 1 cycle.
  - Erase writes data & ~(1<<y[2:0]); set writes data | (1<<y[2:0]). Both use address (y>>3)*COLS + x.
- Timing:
  - Busy time for a move with no erase is RD_LAT+1 cycles; with erase it is 2*(RD_LAT+1).
  - S_WR returns to IDLE.
  - ram_wr_en is 0 outside CLEAR and *_WR.
- Head arithmetic:
  - Coordinates are modulo COLS and PAGES*8 (see optional feature).
  - Compare against COLS-1 explicitly; do not rely on natural width overflow, since COLS need not be a power of 2.

Optional Feature:
- Macro: SNAKE_WRAP_EN.
- Defined: the head wraps at edges (x 0 going left becomes COLS-1; y PAGES*8-1 going down becomes 0).
- Undefined: a move that would leave the screen is accepted but does nothing; there is no history push and no RAM access.

Test Plan:
- Release rst -> busy for exactly 1024 cycles, writes 0x00 to addresses 0..1023, then move_ready=1 and pen_on=0.
- pen_toggle, then move right from (0,0) -> head=(1,0); RAM address 1 bit0 set; busy for 3 cycles; trail_cnt=1.
- 17 moves right with pen_on, TRAIL_LEN=16 -> 17th move erases (1,0) (address 1 becomes 0x00), sets (17,0); trail_cnt stays 16; busy for 6 cycles.
- Moves down/up alternating at x=5 (y 0,1,0,1,...) with a full trail -> popped positions still in history are not erased; the pixels at (5,0) and (5,1) stay lit.
- With SNAKE_WRAP_EN, move left at x=0 -> head_x=127. Without it -> head_x=0 and no RAM write.
- clear_req and move_valid in the same IDLE cycle -> CLEAR sweep runs, move is not accepted, trail_cnt=0 afterwards, head unchanged.
